// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding and frame constants.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO; head is visible on dout, 0 when empty.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_wr, do_rd;

    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_rd = pop & ~empty;
    // a pop frees the slot being written, so push-while-full succeeds alongside a pop
    assign do_wr = push & (~full | do_rd);
    assign dout  = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (8 data bits, optional parity, 1 stop) with
// FWFT receive FIFO and sticky error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);
    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam logic [SC_W-1:0] MID  = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_rx_state_e   state, state_nx;
    logic             rx_m, rx_s, rx_d;
    logic [DIV_W-1:0] cnt;
    logic [SC_W-1:0]  sc;
    logic [2:0]       bc;
    logic [7:0]       shreg;
    logic             par_en_q, par_odd_q, par_bad;
    logic             fall, tick, mid_tick, bit_tick, stop_done;
    logic             push, pop, full, empty;

    assign fall      = rx_d & ~rx_s;
    assign tick      = cnt == '0;
    assign mid_tick  = tick && sc == MID;
    assign bit_tick  = tick && sc == LAST;
    assign stop_done = state == STOP && bit_tick;
    assign push      = stop_done & rx_s & ~par_bad;
    assign pop       = rd_en & rd_valid;
    assign rd_valid  = ~empty;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = fall ? START : IDLE;
            START:   state_nx = mid_tick ? (rx_s ? IDLE : DATA) : START;
            DATA:    state_nx = (bit_tick && bc == LAST_BIT) ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  state_nx = bit_tick ? STOP : PARITY;
            STOP:    state_nx = bit_tick ? IDLE : STOP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            rx_d       <= 1'b1;
            cnt        <= '0;
            sc         <= '0;
            bc         <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
            // reloading on the start edge aligns sample phase to the frame
            cnt  <= ((state == IDLE && fall) || tick) ? baud_div : cnt - 1'b1;
            if (state == IDLE)
                sc <= '0;
            else if (tick)
                sc <= (state == START && sc == MID) ? '0 : sc + 1'b1;
            if (state == START && mid_tick) begin
                bc        <= '0;
                par_en_q  <= parity_en;
                par_odd_q <= parity_odd;
                par_bad   <= 1'b0;
            end
            if (state == DATA && bit_tick) begin
                shreg <= {rx_s, shreg[7:1]};
                bc    <= bc + 1'b1;
            end
            if (state == PARITY && bit_tick)
                par_bad <= rx_s != (^shreg ^ par_odd_q);
            frame_err  <= (stop_done & ~rx_s) | (frame_err & ~clr_err);
            parity_err <= (stop_done & rx_s & par_bad) | (parity_err & ~clr_err);
            overrun    <= (push & full & ~pop) | (overrun & ~clr_err);
        end
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (shreg),
        .pop   (pop),
        .dout  (rd_data),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames; expected bytes queued by stimulus, checked by a draining monitor.
module tb_uart_rx;
    logic        clk = 0;
    logic        reset = 0;
    logic        rx = 1;
    logic [15:0] baud_div = 16'd3;
    logic        parity_en = 0, parity_odd = 0, rd_en = 0, clr_err = 0;
    logic [7:0]  rd_data;
    logic        rd_valid, busy, frame_err, parity_err, overrun;

    int          checks = 0, errors = 0;
    bit          drain = 0;
    logic [7:0]  q[$];
    localparam int BIT_CLKS = 64;

    uart_rx dut (
        .clk(clk), .reset(reset), .rx(rx), .baud_div(baud_div),
        .parity_en(parity_en), .parity_odd(parity_odd), .rd_en(rd_en), .clr_err(clr_err),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx = b;
        repeat (BIT_CLKS - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit par, input logic par_bit, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par) drive_bit(par_bit);
        drive_bit(stop);
        drive_bit(1'b1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1;
        @(negedge clk);
        clr_err = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || rd_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", {7'd0, n < 3000}, 8'd1);
    endtask

    task automatic chk_flags(input string name, input logic [2:0] exp);
        chk(name, {5'd0, frame_err, parity_err, overrun}, {5'd0, exp});
    endtask

    // monitor: pops the FIFO head every other cycle and scores it against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (rd_en) rd_en = 0;
            else if (drain && rd_valid) begin
                if (q.size() == 0) chk("spurious_byte", {7'd0, rd_valid}, 8'd0);
                else chk("rd_data", rd_data, q.pop_front());
                rd_en = 1;
            end
        end
    end

    initial begin
        #1;
        chk("rst_valid", {7'd0, rd_valid}, 8'd0);
        chk("rst_data", rd_data, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk_flags("rst_flags", 3'b000);
        repeat (3) @(negedge clk);
        reset = 1;
        repeat (4) @(negedge clk);

        drain = 1;
        q.push_back(8'hA5);
        send_byte(8'hA5, 0, 0, 1);
        wait_drain();
        chk("empty_valid", {7'd0, rd_valid}, 8'd0);
        chk("empty_data", rd_data, 8'd0);
        chk_flags("a5_flags", 3'b000);

        parity_en = 1;
        send_byte(8'h03, 1, 1'b1, 1);
        chk_flags("par_err", 3'b010);
        chk("par_valid", {7'd0, rd_valid}, 8'd0);
        pulse_clr();
        chk_flags("par_clr", 3'b000);
        parity_odd = 1;
        q.push_back(8'h07);
        send_byte(8'h07, 1, 1'b0, 1);
        wait_drain();
        chk_flags("odd_ok", 3'b000);
        parity_en = 0;
        parity_odd = 0;

        send_byte(8'h55, 0, 0, 0);
        chk_flags("frame_err", 3'b100);
        chk("frame_valid", {7'd0, rd_valid}, 8'd0);
        q.push_back(8'h12);
        send_byte(8'h12, 0, 0, 1);
        wait_drain();
        pulse_clr();
        chk_flags("frame_clr", 3'b000);

        @(negedge clk);
        rx = 0;
        repeat (10) @(negedge clk);
        chk("glitch_busy", {7'd0, busy}, 8'd1);
        repeat (10) @(negedge clk);
        rx = 1;
        repeat (100) @(negedge clk);
        chk("glitch_idle", {7'd0, busy}, 8'd0);
        chk("glitch_valid", {7'd0, rd_valid}, 8'd0);
        chk_flags("glitch_flags", 3'b000);

        drain = 0;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 0, 0, 1);
        chk_flags("overrun", 3'b001);
        chk("ovr_head", rd_data, 8'h01);
        for (int i = 1; i <= 4; i++) q.push_back(8'(i));
        drain = 1;
        wait_drain();
        pulse_clr();
        chk_flags("ovr_clr", 3'b000);

        drain = 0;
        send_byte(8'h77, 0, 0, 1);
        send_byte(8'h55, 0, 0, 0);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (32) @(negedge clk);
        chk("pre_rst_busy", {7'd0, busy}, 8'd1);
        chk("pre_rst_valid", {7'd0, rd_valid}, 8'd1);
        chk_flags("pre_rst_flags", 3'b100);
        reset = 0;
        #1;
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk("mid_rst_valid", {7'd0, rd_valid}, 8'd0);
        chk("mid_rst_data", rd_data, 8'd0);
        chk_flags("mid_rst_flags", 3'b000);
        @(negedge clk);
        reset = 1;
        repeat (5 * BIT_CLKS) @(negedge clk);
        chk("post_rst_busy", {7'd0, busy}, 8'd0);
        drain = 1;
        q.push_back(8'h3C);
        send_byte(8'h3C, 0, 0, 1);
        wait_drain();
        chk_flags("final_flags", 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
